// File: rtl/cx_alu_pkg.sv
// Shared definitions for the cx ALU pipeline.
//   OP_W        : opcode width
//   cx_op_e     : opcode encodings (ADD..SHR); codes 10..15 are unknown
//   cx_state_e  : control FSM states
package cx_alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_MOD = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } cx_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    DWAIT
  } cx_state_e;

endpackage

// File: rtl/cx_div_iter.sv
// Iterative restoring divider, one quotient bit per clock.
//   clk, reset : clock, synchronous active-high reset
//   start      : load a/b and begin a W-step division
//   a, b       : dividend, divisor (b must be non-zero)
//   busy       : a division step runs this cycle
//   done       : this cycle performs the final step
//   quo, rem   : during a step, the values that step produces; when idle,
//                the results of the last completed division
module cx_div_iter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);

  localparam int unsigned CW = $clog2(W);

  logic [CW-1:0] cnt;
  logic [W-1:0]  quo_q;   // dividend bits shift out the top, quotient bits in
  logic [W-1:0]  rem_q;
  logic [W-1:0]  dvs_q;
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic [W-1:0]  quo_step;
  logic [W-1:0]  rem_step;

  always_comb begin
    trial    = {rem_q, quo_q[W-1]};
    diff     = trial - {1'b0, dvs_q};
    // No borrow out of the top bit means the divisor fits.
    rem_step = diff[W] ? trial[W-1:0] : diff[W-1:0];
    quo_step = {quo_q[W-2:0], ~diff[W]};
  end

  assign done = busy && (cnt == CW'(W - 1));
  assign quo  = busy ? quo_step : quo_q;
  assign rem  = busy ? rem_step : rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      quo_q <= a;
      rem_q <= '0;
      dvs_q <= b;
    end else if (busy) begin
      quo_q <= quo_step;
      rem_q <= rem_step;
      cnt   <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/cx_alu_pipe.sv
// cx ALU pipeline: W-bit unsigned operands, 2W-bit result, valid/ready both sides.
// Single-cycle ops stream at one per clock; DIV/MOD (b != 0) run on an
// iterative divider when CX_ALU_DIV_EN is defined, otherwise ops 3/7 are
// reported as unknown opcodes.
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready       : operand beat handshake (in_ready independent of in_valid)
//   in_a, in_b, in_op       : operands and opcode
//   out_valid/out_ready     : result beat handshake
//   out_result, out_err     : result and error flag (unknown op / divide by zero)
// Macro: CX_ALU_DIV_EN enables the iterative divider.
module cx_alu_pipe #(
  parameter int unsigned W    = 8,
  parameter int unsigned OP_W = cx_alu_pkg::OP_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [OP_W-1:0] in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_result,
  output logic            out_err
);

  import cx_alu_pkg::*;

  localparam int unsigned RW   = 2 * W;
  localparam int unsigned SH_W = $clog2(RW);

  cx_state_e       state, state_n;
  logic [W-1:0]    s1_a, s1_b;
  logic [OP_W-1:0] s1_op;
  logic            slot_free, s1_iter, accept, load_out;
  logic [RW-1:0]   a2, b2, alu_res, out_result_n;
  logic            alu_err, out_err_n;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) || ((state == EXEC) && slot_free && !s1_iter);
  assign accept    = in_valid && in_ready;

`ifdef CX_ALU_DIV_EN
  logic          div_start, div_busy, div_done;
  logic [W-1:0]  div_quo, div_rem;
  logic [RW-1:0] div_val;

  assign s1_iter = ((s1_op == OP_W'(OP_DIV)) || (s1_op == OP_W'(OP_MOD))) && (s1_b != '0);
  assign div_val = (s1_op == OP_W'(OP_MOD)) ? RW'(div_rem) : RW'(div_quo);

  cx_div_iter #(.W(W)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .a     (s1_a),
    .b     (s1_b),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo),
    .rem   (div_rem)
  );
`else
  assign s1_iter = 1'b0;
`endif

  // DIV/MOD only reach the single-cycle path when they are errors (b == 0,
  // or no divider built), so they share the unknown-opcode default.
  always_comb begin
    a2      = RW'(s1_a);
    b2      = RW'(s1_b);
    alu_res = '0;
    alu_err = 1'b0;
    case (s1_op)
      OP_W'(OP_ADD): alu_res = a2 + b2;
      OP_W'(OP_SUB): alu_res = a2 - b2;
      OP_W'(OP_MUL): alu_res = a2 * b2;
      OP_W'(OP_AND): alu_res = a2 & b2;
      OP_W'(OP_OR):  alu_res = a2 | b2;
      OP_W'(OP_XOR): alu_res = a2 ^ b2;
      OP_W'(OP_SHL): alu_res = a2 << s1_b[SH_W-1:0];
      OP_W'(OP_SHR): alu_res = a2 >> s1_b[SH_W-1:0];
      default:       alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_n      = state;
    load_out     = 1'b0;
    out_result_n = alu_res;
    out_err_n    = alu_err;
`ifdef CX_ALU_DIV_EN
    div_start    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) state_n = EXEC;
      end
      EXEC: begin
        if (s1_iter) begin
`ifdef CX_ALU_DIV_EN
          div_start = 1'b1;
          state_n   = DIV;
`endif
        end else if (slot_free) begin
          load_out = 1'b1;
          if (!accept) state_n = IDLE;
        end
      end
`ifdef CX_ALU_DIV_EN
      // The final divider step is written straight to the output when the
      // slot is free; DWAIT only absorbs backpressure on the result.
      DIV: begin
        if (div_done) begin
          out_result_n = div_val;
          out_err_n    = 1'b0;
          if (slot_free) begin
            load_out = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n  = DWAIT;
          end
        end
      end
      DWAIT: begin
        out_result_n = div_val;
        out_err_n    = 1'b0;
        if (slot_free && !div_busy) begin
          load_out = 1'b1;
          state_n  = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= in_op;
      end
      if (load_out) begin
        out_valid  <= 1'b1;
        out_result <= out_result_n;
        out_err    <= out_err_n;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cx_alu_pipe.sv
// Self-checking bench for cx_alu_pipe (W=8). Expected results are queued when
// a beat is accepted and compared, with latency, when the result transfers.
// Honours CX_ALU_DIV_EN for the DIV/MOD expectations.
module tb_cx_alu_pipe;
  import cx_alu_pkg::*;

  localparam int unsigned W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [3:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        out_err;

  cx_alu_pipe #(.W(W), .OP_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int unsigned acc;
    int unsigned lat;
    string       tag;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
    int unsigned lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: samples 2 ns before each rising edge.
  logic        hold_prev = 1'b0;
  logic [15:0] res_prev = '0;
  logic        err_prev = 1'b0;
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid",  32'(out_valid),  32'd1);
        check("hold_result", 32'(out_result), 32'(res_prev));
        check("hold_err",    32'(out_err),    32'(err_prev));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result 0x%0h err %0d, expected no output", out_result, out_err);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_result"}, 32'(out_result), 32'(e.res));
          check({e.tag, "_err"},    32'(out_err),    32'(e.err));
          if (e.lat != 0) check({e.tag, "_latency"}, cyc - e.acc, e.lat);
        end
      end
      hold_prev = out_valid && !out_ready;
      res_prev  = out_result;
      err_prev  = out_err;
    end
  end

  task automatic wait_accept(input logic [15:0] res, input logic err, input int unsigned lat,
                             input bit push, input string tag);
    for (int i = 0; i < 200; i++) begin
      #3;
      if (in_ready) begin
        if (push) sb.push_back('{res: res, err: err, acc: cyc, lat: lat, tag: tag});
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s_accept: in_ready stayed 0 for 200 cycles, expected 1", tag);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [15:0] res, input logic err, input int unsigned lat,
                      input bit push, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    wait_accept(res, err, lat, push, tag);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && !out_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_drain: %0d results outstanding after 300 cycles, expected 0", tag, sb.size());
    sb.delete();
  endtask

  initial begin
    int unsigned t0;

    vecs.push_back('{op: OP_ADD, a: 8'hFF, b: 8'h01, res: 16'h0100, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_SUB, a: 8'h01, b: 8'h00, res: 16'h0001, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_MUL, a: 8'hFF, b: 8'hFF, res: 16'hFE01, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_XOR, a: 8'hF0, b: 8'h3C, res: 16'h00CC, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_SUB, a: 8'h00, b: 8'h01, res: 16'hFFFF, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_AND, a: 8'hF0, b: 8'h3C, res: 16'h0030, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_OR,  a: 8'hF0, b: 8'h3C, res: 16'h00FC, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_SHL, a: 8'h81, b: 8'h04, res: 16'h0810, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_SHR, a: 8'hF0, b: 8'h04, res: 16'h000F, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_SHL, a: 8'h01, b: 8'h13, res: 16'h0008, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_SHL, a: 8'hFF, b: 8'h0F, res: 16'h8000, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_SHR, a: 8'hF0, b: 8'h07, res: 16'h0001, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_ADD, a: 8'hFF, b: 8'hFF, res: 16'h01FE, err: 1'b0, lat: 2});
    vecs.push_back('{op: OP_DIV, a: 8'h05, b: 8'h00, res: 16'h0000, err: 1'b1, lat: 2});
    vecs.push_back('{op: OP_MOD, a: 8'h09, b: 8'h00, res: 16'h0000, err: 1'b1, lat: 2});
    vecs.push_back('{op: 4'hC,   a: 8'h12, b: 8'h34, res: 16'h0000, err: 1'b1, lat: 2});
    vecs.push_back('{op: 4'hF,   a: 8'h00, b: 8'h00, res: 16'h0000, err: 1'b1, lat: 2});
`ifdef CX_ALU_DIV_EN
    vecs.push_back('{op: OP_DIV, a: 8'hFF, b: 8'h01, res: 16'h00FF, err: 1'b0, lat: W + 2});
    vecs.push_back('{op: OP_MOD, a: 8'hFF, b: 8'h10, res: 16'h000F, err: 1'b0, lat: W + 2});
    vecs.push_back('{op: OP_DIV, a: 8'h03, b: 8'hC8, res: 16'h0000, err: 1'b0, lat: W + 2});
    vecs.push_back('{op: OP_MOD, a: 8'h03, b: 8'hC8, res: 16'h0003, err: 1'b0, lat: W + 2});
`else
    vecs.push_back('{op: OP_DIV, a: 8'hFF, b: 8'h01, res: 16'h0000, err: 1'b1, lat: 2});
    vecs.push_back('{op: OP_MOD, a: 8'hFF, b: 8'h10, res: 16'h0000, err: 1'b1, lat: 2});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    check("reset_out_valid",  32'(out_valid),  32'd0);
    check("reset_out_result", 32'(out_result), 32'd0);
    check("reset_out_err",    32'(out_err),    32'd0);
    check("reset_in_ready",   32'(in_ready),   32'd1);

    // Table vectors, back to back
    foreach (vecs[i])
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].err, vecs[i].lat, 1'b1,
           $sformatf("vec%0d", i));
    idle();
    drain("table");

    // DIV then MOD 200/7 with in_ready held low through the division
`ifdef CX_ALU_DIV_EN
    send(8'd200, 8'd7, OP_DIV, 16'h001C, 1'b0, W + 2, 1'b1, "div200_7");
    t0 = cyc;
    @(negedge clk);
    in_op = OP_MOD;
    for (int k = 0; k < W + 1; k++) begin
      #3;
      check("div_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    wait_accept(16'h0004, 1'b0, W + 2, 1'b1, "mod200_7");
    check("mod_accept_cycle", cyc - t0, W + 2);
    idle();
`else
    send(8'd200, 8'd7, OP_DIV, 16'h0000, 1'b1, 2, 1'b1, "div200_7");
    send(8'd200, 8'd7, OP_MOD, 16'h0000, 1'b1, 2, 1'b1, "mod200_7");
    idle();
`endif
    drain("divmod");

    // Backpressure: two ADDs fit, the third waits until out_ready returns
    @(negedge clk);
    out_ready = 1'b0;
    send(8'd1, 8'd2, OP_ADD, 16'h0003, 1'b0, 0, 1'b1, "bp_add1");
    send(8'd10, 8'd20, OP_ADD, 16'h001E, 1'b0, 0, 1'b1, "bp_add2");
    @(negedge clk);
    in_a = 8'h80;
    in_b = 8'h80;
    for (int k = 0; k < 3; k++) begin
      #3;
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_accept(16'h0100, 1'b0, 2, 1'b1, "bp_add3");
    idle();
    drain("backpressure");

    // Reset during division at cnt=3
`ifdef CX_ALU_DIV_EN
    send(8'd200, 8'd7, OP_DIV, 16'h0000, 1'b0, 0, 1'b0, "div_abort");
`else
    send(8'd200, 8'd7, OP_DIV, 16'h0000, 1'b1, 2, 1'b1, "div_abort");
`endif
    idle();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    check("abort_out_valid",  32'(out_valid),  32'd0);
    check("abort_in_ready",   32'(in_ready),   32'd1);
    check("abort_out_result", 32'(out_result), 32'd0);
    send(8'd2, 8'd3, OP_ADD, 16'h0005, 1'b0, 2, 1'b1, "post_abort_add");
    idle();
    drain("abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation reached 500000 time units, expected to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
